// File: rtl/lcd_timing_gen.sv
// RGB LCD timing generator with FIFO-fed pixels; LCD_TIMING_RGB888_EN selects 24-bit pixels (default RGB565).
// Counters to pins take 1 cycle; the FIFO is never stalled, and an empty FIFO costs one background pixel.
module lcd_timing_gen #(
    parameter int          H_ACTIVE = 800,
    parameter int          H_FP     = 40,
    parameter int          H_SYNC   = 48,
    parameter int          H_BP     = 88,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 13,
    parameter int          V_SYNC   = 3,
    parameter int          V_BP     = 32,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter logic [23:0] BG_COLOR = 24'hFF0000,
`ifdef LCD_TIMING_RGB888_EN
    localparam int         PIX_W    = 24
`else
    localparam int         PIX_W    = 16
`endif
) (
    input  logic             PixelClk,
    input  logic             RST,
    input  logic             EN,
    input  logic [PIX_W-1:0] FIFO_Data,
    input  logic             FIFO_Empty,
    output logic             FIFO_RE,
    output logic             FIFO_RST,
    output logic             LCD_DE,
    output logic             LCD_HSYNC,
    output logic             LCD_VSYNC,
    output logic [7:0]       LCD_R,
    output logic [7:0]       LCD_G,
    output logic [7:0]       LCD_B,
    output logic             FrameStart,
    output logic [15:0]      UnderflowCnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] hc_q, hc_d;
    logic [VW-1:0] vc_q, vc_d;
    logic          de_q, de_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          fs_q, fs_d;
    logic          rd_q, rd_d;
    logic [15:0]   ucnt_q, ucnt_d;
    logic          act, under, in_hs, in_vs;
    logic [23:0]   pix;

    always_comb begin
        act      = (hc_q < H_ACT) && (vc_q < V_ACT);
        under    = act && FIFO_Empty;
        in_hs    = (hc_q >= HS_START) && (hc_q < HS_END);
        in_vs    = (vc_q >= VS_START) && (vc_q < VS_END);
        FIFO_RE  = act && !FIFO_Empty && EN;
        // Flush once per frame during V sync so stale words never leak into the next frame.
        FIFO_RST = RST || !EN || in_vs;
    end

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (!EN) begin
            hc_d = '0;
            vc_d = V_ACT;
        end else if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
        end else begin
            hc_d = hc_q + 1'b1;
        end
    end

    always_comb begin
        de_d   = 1'b0;
        hs_d   = ~HS_POL;
        vs_d   = ~VS_POL;
        fs_d   = 1'b0;
        rd_d   = 1'b0;
        ucnt_d = ucnt_q;
        if (EN) begin
            de_d = act;
            hs_d = in_hs ? HS_POL : ~HS_POL;
            vs_d = in_vs ? VS_POL : ~VS_POL;
            fs_d = (hc_q == '0) && (vc_q == '0);
            rd_d = FIFO_RE;
            if (under && (ucnt_q != 16'hFFFF))
                ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            hc_q   <= '0;
            vc_q   <= V_ACT;
            de_q   <= 1'b0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            fs_q   <= 1'b0;
            rd_q   <= 1'b0;
            ucnt_q <= 16'd0;
        end else begin
            hc_q   <= hc_d;
            vc_q   <= vc_d;
            de_q   <= de_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            fs_q   <= fs_d;
            rd_q   <= rd_d;
            ucnt_q <= ucnt_d;
        end
    end

    // FIFO data arrives the cycle after the read, which is exactly when rd_q is high.
    always_comb begin
        pix = 24'h000000;
        if (rd_q) begin
`ifdef LCD_TIMING_RGB888_EN
            pix = FIFO_Data;
`else
            pix = {FIFO_Data[15:11], FIFO_Data[15:13],
                   FIFO_Data[10:5],  FIFO_Data[10:9],
                   FIFO_Data[4:0],   FIFO_Data[4:2]};
`endif
        end else if (de_q) begin
            pix = BG_COLOR;
        end
    end

    assign LCD_R        = pix[23:16];
    assign LCD_G        = pix[15:8];
    assign LCD_B        = pix[7:0];
    assign LCD_DE       = de_q;
    assign LCD_HSYNC    = hs_q;
    assign LCD_VSYNC    = vs_q;
    assign FrameStart   = fs_q;
    assign UnderflowCnt = ucnt_q;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen on a 14x7 raster: scan-position reference model, pixel tables and corner sequences.
module tb_lcd_timing_gen;
`ifdef LCD_TIMING_RGB888_EN
    localparam int PW = 24;
`else
    localparam int PW = 16;
`endif
    localparam int HT    = 14;
    localparam int TOT   = 98;
    localparam int START = 4 * HT;

    logic          clk = 1'b0;
    logic          rst, en, fifo_empty;
    logic [PW-1:0] fifo_data;
    logic          fifo_re, fifo_rst, lcd_de, lcd_hs, lcd_vs, fs;
    logic [7:0]    lcd_r, lcd_g, lcd_b;
    logic [15:0]   ucnt;

    lcd_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .BG_COLOR(24'hFF0000)
    ) dut (
        .PixelClk(clk), .RST(rst), .EN(en), .FIFO_Data(fifo_data), .FIFO_Empty(fifo_empty),
        .FIFO_RE(fifo_re), .FIFO_RST(fifo_rst), .LCD_DE(lcd_de), .LCD_HSYNC(lcd_hs),
        .LCD_VSYNC(lcd_vs), .LCD_R(lcd_r), .LCD_G(lcd_g), .LCD_B(lcd_b),
        .FrameStart(fs), .UnderflowCnt(ucnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: n = enabled edges since scanning (re)started; position is plain raster arithmetic.
    int   n = 0;
    int   m_ucnt = 0;
    logic m_de = 1'b0, m_hs = 1'b1, m_vs = 1'b1, m_fs = 1'b0, m_rd = 1'b0;

    typedef struct { logic [23:0] d; logic [7:0] r, g, b; } vec_t;
    vec_t tbl[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pos();
        return (START + n) % TOT;
    endfunction

    function automatic bit active_at(int p);
        return ((p % HT) < 8) && ((p / HT) < 4);
    endfunction

    function automatic logic [23:0] expand(logic [PW-1:0] d);
        int r5, g6, b5, v;
        v = int'(d);
`ifdef LCD_TIMING_RGB888_EN
        return 24'(v);
`else
        r5 = (v / 2048) % 32;
        g6 = (v / 32) % 64;
        b5 = v % 32;
        return {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
`endif
    endfunction

    task automatic model_clear(input bit clear_cnt);
        n = 0;
        m_de = 1'b0; m_hs = 1'b1; m_vs = 1'b1; m_fs = 1'b0; m_rd = 1'b0;
        if (clear_cnt) m_ucnt = 0;
    endtask

    task automatic check_now();
        int p;
        logic [23:0] exp_pix;
        p = pos();
        exp_pix = m_rd ? expand(fifo_data) : (m_de ? 24'hFF0000 : 24'h000000);
        chk("fifo_re",  fifo_re,  (en && !rst) ? 32'(active_at(p) && !fifo_empty) : 32'd0);
        chk("fifo_rst", fifo_rst, 32'(rst || !en || ((p / HT) == 5)));
        chk("de",       lcd_de,   m_de);
        chk("hsync",    lcd_hs,   m_hs);
        chk("vsync",    lcd_vs,   m_vs);
        chk("framestart", fs,     m_fs);
        chk("rgb",      {lcd_r, lcd_g, lcd_b}, exp_pix);
        chk("ucnt",     ucnt,     m_ucnt);
    endtask

    task automatic tick();
        int p, h, v;
        bit a;
        logic e, en_s, rst_s;
        p = pos(); h = p % HT; v = p / HT; a = active_at(p);
        e = fifo_empty; en_s = en; rst_s = rst;
        @(posedge clk);
        if (rst_s) begin
            model_clear(1'b1);
        end else if (!en_s) begin
            model_clear(1'b0);
        end else begin
            m_de = a;
            m_hs = !((h >= 10) && (h < 12));
            m_vs = !(v == 5);
            m_fs = (p == 0);
            m_rd = a && !e;
            if (a && e && m_ucnt < 65535) m_ucnt++;
            n = (n + 1) % TOT;
        end
        #1;
    endtask

    task automatic cycle(input logic emp, input logic [PW-1:0] d);
        fifo_empty = emp;
        fifo_data  = d;
        #1;
        check_now();
        tick();
    endtask

    task automatic count_to_fs(input string name, input int required);
        int k;
        k = 0;
        while (k < 300) begin
            cycle(1'b0, PW'($urandom));
            k++;
            if (fs === 1'b1) break;
        end
        chk(name, k, required);
    endtask

    task automatic apply_vec(input int i);
        int k;
        k = 0;
        while (!m_rd && k < 200) begin
            cycle(1'b0, PW'($urandom));
            k++;
        end
        chk("vec_wait", 32'(m_rd), 32'd1);
        fifo_empty = 1'b0;
        fifo_data  = PW'(tbl[i].d);
        #1;
        check_now();
        chk("vec_r", lcd_r, tbl[i].r);
        chk("vec_g", lcd_g, tbl[i].g);
        chk("vec_b", lcd_b, tbl[i].b);
        chk("vec_de", lcd_de, 1);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        int k, de_cnt, vs_cnt, rst_cnt, hs_cnt, rise_idx, gap;
        logic prev_de, prev_hs;
        int u0;
`ifdef LCD_TIMING_RGB888_EN
        tbl[0] = '{24'h123456, 8'h12, 8'h34, 8'h56};
        tbl[1] = '{24'hFFFFFF, 8'hFF, 8'hFF, 8'hFF};
        tbl[2] = '{24'h00A501, 8'h00, 8'hA5, 8'h01};
`else
        tbl[0] = '{24'h00F800, 8'hFF, 8'h00, 8'h00};
        tbl[1] = '{24'h0007E0, 8'h00, 8'hFF, 8'h00};
        tbl[2] = '{24'h000841, 8'h08, 8'h08, 8'h08};
`endif
        rst = 1'b1; en = 1'b0; fifo_empty = 1'b0; fifo_data = '0;
        model_clear(1'b1);
        #2;
        chk("rst_fifo_rst", fifo_rst, 1);
        chk("rst_de", lcd_de, 0);
        chk("rst_hs", lcd_hs, 1);
        chk("rst_rgb", {lcd_r, lcd_g, lcd_b}, 0);
        repeat (3) cycle(1'b0, PW'($urandom));

        // Held in reset with EN high: outputs must stay at reset values.
        en = 1'b1;
        repeat (3) cycle(1'b0, PW'($urandom));
        rst = 1'b0;
        count_to_fs("first_framestart", 43);
        count_to_fs("framestart_period", 98);

        // One full frame of shape measurements.
        de_cnt = 0; vs_cnt = 0; rst_cnt = 0; hs_cnt = 0; rise_idx = -1; gap = -1;
        prev_de = lcd_de; prev_hs = lcd_hs;
        for (int i = 0; i < TOT; i++) begin
            cycle(1'b0, PW'($urandom));
            if (lcd_de) de_cnt++;
            if (!lcd_vs) vs_cnt++;
            if (fifo_rst) rst_cnt++;
            if (!lcd_hs) hs_cnt++;
            if (lcd_de && !prev_de) rise_idx = i;
            if (!lcd_hs && prev_hs && rise_idx >= 0 && gap < 0) gap = i - rise_idx;
            prev_de = lcd_de; prev_hs = lcd_hs;
        end
        chk("de_per_frame", de_cnt, 32);
        chk("vsync_low_cycles", vs_cnt, 14);
        chk("fifo_rst_cycles", rst_cnt, 14);
        chk("hsync_low_cycles", hs_cnt, 14);
        chk("de_to_hsync", gap, 10);

        for (int i = 0; i < 3; i++) apply_vec(i);

        // Three-pixel underflow in the middle of an active line.
        k = 0;
        while (!(((pos() % HT) == 2) && ((pos() / HT) < 4)) && k < 200) begin
            cycle(1'b0, PW'($urandom));
            k++;
        end
        u0 = int'(ucnt);
        for (int i = 0; i < 3; i++) begin
            fifo_empty = 1'b1;
            #1;
            check_now();
            chk("uf_re", fifo_re, 0);
            tick();
            chk("uf_rgb", {lcd_r, lcd_g, lcd_b}, 24'hFF0000);
            chk("uf_de", lcd_de, 1);
        end
        cycle(1'b0, PW'($urandom));
        chk("uf_delta", int'(ucnt) - u0, 3);

        // Asynchronous reset at hc=5 of an active line.
        k = 0;
        while (!(((pos() % HT) == 5) && ((pos() / HT) < 4)) && k < 200) begin
            cycle(1'b0, PW'($urandom));
            k++;
        end
        chk("mid_de_before", lcd_de, 1);
        rst = 1'b1;
        model_clear(1'b1);
        #1;
        chk("mid_rst_de", lcd_de, 0);
        chk("mid_rst_fifo_rst", fifo_rst, 1);
        chk("mid_rst_ucnt", ucnt, 0);
        repeat (2) cycle(1'b0, PW'($urandom));
        rst = 1'b0;
        count_to_fs("fs_after_reset", 43);

        // Random FIFO-empty pattern, then EN drop mid-frame (count must hold).
        for (int i = 0; i < 2 * TOT; i++) cycle(($urandom % 4) == 0, PW'($urandom));
        u0 = int'(ucnt);
        en = 1'b0;
        repeat (5) cycle(($urandom % 2) == 0, PW'($urandom));
        chk("en_off_ucnt_hold", ucnt, u0);
        chk("en_off_de", lcd_de, 0);
        en = 1'b1;
        count_to_fs("fs_after_enable", 43);
        for (int i = 0; i < TOT; i++) cycle(($urandom % 3) == 0, PW'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
